// File: rtl/madd_rr_scheduler.sv
// madd_rr_scheduler
//   Round-robin front end that shares one pipelined multiply-add unit
//   (s = a*b + c, latency LAT) between NREQ requesters. The requester ID
//   travels alongside the datapath in a tag pipeline, so each result is
//   steered back to the requester that issued it. An enable/drain FSM lets
//   software stop new grants and wait for in-flight work to finish.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   en                      1 = grant new requests, 0 = stop and drain
//   req_valid/req_ready     per-requester handshake (ready is one-hot or 0)
//   req_a/req_b/req_c       packed operands, requester i at [i*WIDTH +: WIDTH]
//   madd_a/madd_b/madd_c    operands to the shared datapath (0 when no grant)
//   madd_s                  datapath result, LAT cycles after operand sample
//   rsp_valid/rsp_s         registered one-hot response strobe and data
//   busy                    any tag stage valid
//   state                   IDLE=0, RUN=1, DRAIN=2
module madd_rr_scheduler #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 2,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*WIDTH-1:0]   req_c,
  output logic [WIDTH-1:0]        madd_a,
  output logic [WIDTH-1:0]        madd_b,
  output logic [WIDTH-1:0]        madd_c,
  input  logic [2*WIDTH-1:0]      madd_s,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_s,
  output logic                    busy,
  output logic [1:0]              state
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             st_q, st_d;
  logic [IDW-1:0]     ptr_q;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [LAT-1:0]     vld_pipe;
  logic [LAT-1:0][IDW-1:0] id_pipe;

  // Rotating-priority search: the slot after the last winner goes first.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_any   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    if (st_q == S_RUN && en) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (int'(ptr_q) + k) % NREQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  // A grant is only ever given to a valid requester, so grant == transfer.
  assign madd_a = gnt_any ? req_a[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign madd_b = gnt_any ? req_b[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign madd_c = gnt_any ? req_c[int'(gnt_id)*WIDTH +: WIDTH] : '0;

  assign busy  = |vld_pipe;
  assign state = st_q;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE:  if (en) st_d = S_RUN;
      // No grant can coincide with en=0, so busy alone decides the exit.
      S_RUN:   if (!en) st_d = busy ? S_DRAIN : S_IDLE;
      S_DRAIN: if (en) st_d = S_RUN;
               else if (!busy) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      ptr_q     <= IDW'(NREQ-1);
      vld_pipe  <= '0;
      rsp_valid <= '0;
      rsp_s     <= '0;
    end else begin
      st_q <= st_d;
      if (gnt_any) ptr_q <= gnt_id;
      vld_pipe[0] <= gnt_any;
      for (int i = 1; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (vld_pipe[LAT-1]) begin
        rsp_valid <= NREQ'(1) << id_pipe[LAT-1];
        rsp_s     <= madd_s;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  // IDs are only meaningful under their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    id_pipe[0] <= gnt_id;
    for (int i = 1; i < LAT; i++) id_pipe[i] <= id_pipe[i-1];
  end

endmodule

// File: tb/tb_madd_rr_scheduler.sv
module tb_madd_rr_scheduler;
  localparam int W = 3;
  localparam int N = 2;
  localparam int L = 2;

  logic             clk = 1'b0;
  logic             rst_n, en;
  logic [N-1:0]     req_valid, req_ready, rsp_valid;
  logic [N*W-1:0]   req_a, req_b, req_c;
  logic [W-1:0]     madd_a, madd_b, madd_c;
  logic [2*W-1:0]   madd_s, rsp_s;
  logic             busy;
  logic [1:0]       state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  madd_rr_scheduler #(.WIDTH(W), .NREQ(N), .LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .madd_a(madd_a), .madd_b(madd_b), .madd_c(madd_c), .madd_s(madd_s),
    .rsp_valid(rsp_valid), .rsp_s(rsp_s), .busy(busy), .state(state)
  );

  // Behavioural multiply-add unit: L register stages, no reset, no stall.
  logic [2*W-1:0] dp [L];
  always @(posedge clk) begin
    dp[0] <= {{W{1'b0}}, madd_a} * {{W{1'b0}}, madd_b} + {{W{1'b0}}, madd_c};
    for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
  end
  assign madd_s = dp[L-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [N-1:0] v,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [W-1:0] c0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [W-1:0] c1);
    req_valid = v;
    req_a = {a1, a0};
    req_b = {b1, b0};
    req_c = {c1, c0};
  endtask

  initial begin
    logic [N-1:0] g;
    rst_n = 1'b0; en = 1'b0;
    set_ops(2'b00, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    chk("rst_ready", req_ready, 0);

    // Single request 7*7+7 = 56
    en = 1'b1;
    tick();
    chk("run_state", state, 1);
    set_ops(2'b01, 7, 7, 7, 0, 0, 0);
    #1;
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_madd_a", madd_a, 7);
    tick();
    set_ops(2'b00, 0, 0, 0, 0, 0, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_rsp_early", rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_s", rsp_s, 56);
    tick();
    chk("t1_rsp_drop", rsp_valid, 0);
    chk("t1_rsp_hold", rsp_s, 56);
    chk("t1_busy_end", busy, 0);

    // Both requesters contend; last winner was req0 so req1 leads.
    // req0: 1*2+3=5, req1: 2*3+1=7
    for (int i = 0; i < 9; i++) begin
      if (i >= 3) begin
        g = ((i - 3) % 2 == 0) ? 2'b10 : 2'b01;
        chk("rr_rsp_valid", rsp_valid, g);
        chk("rr_rsp_s", rsp_s, (g == 2'b10) ? 7 : 5);
      end else begin
        chk("rr_rsp_idle", rsp_valid, 0);
      end
      if (i < 6) set_ops(2'b11, 1, 2, 3, 2, 3, 1);
      else       set_ops(2'b00, 0, 0, 0, 0, 0, 0);
      #1;
      if (i < 6) chk("rr_ready", req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end

    // Pointer behaviour: req1 alone three times, then both -> req0
    for (int i = 0; i < 4; i++) begin
      set_ops((i < 3) ? 2'b10 : 2'b11, 1, 2, 3, 2, 3, 1);
      #1;
      chk("ptr_ready", req_ready, (i < 3) ? 2'b10 : 2'b01);
      tick();
    end
    set_ops(2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("ptr_flush_busy", busy, 0);

    // Drain: two grants (req1 then req0), then drop en with requests held
    set_ops(2'b11, 1, 2, 3, 2, 3, 1);
    #1;
    chk("dr_ready0", req_ready, 2'b10);
    tick();
    chk("dr_ready1", req_ready, 2'b01);
    tick();
    en = 1'b0;
    #1;
    chk("dr_ready_off", req_ready, 0);
    chk("dr_state_run", state, 1);
    tick();
    chk("dr_state_drain", state, 2);
    chk("dr_rsp0_valid", rsp_valid, 2'b10);
    chk("dr_rsp0_s", rsp_s, 7);
    chk("dr_busy0", busy, 1);
    chk("dr_ready_drain", req_ready, 0);
    tick();
    chk("dr_rsp1_valid", rsp_valid, 2'b01);
    chk("dr_rsp1_s", rsp_s, 5);
    chk("dr_busy1", busy, 0);
    chk("dr_state_still", state, 2);
    tick();
    chk("dr_state_idle", state, 0);
    chk("dr_rsp_none", rsp_valid, 0);
    set_ops(2'b00, 0, 0, 0, 0, 0, 0);

    // Reset with two operations in flight
    en = 1'b1;
    tick();
    set_ops(2'b11, 1, 2, 3, 2, 3, 1);
    #1;
    chk("rf_ready0", req_ready, 2'b10);
    tick();
    tick();
    set_ops(2'b00, 0, 0, 0, 0, 0, 0);
    chk("rf_busy_pre", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rf_busy", busy, 0);
    chk("rf_state", state, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rf_no_rsp", rsp_valid, 0);
      tick();
    end

    // Post-reset grant goes to req0; boundary operands
    // req0: 0*5+0=0, req1: 7*0+7=7
    tick();
    chk("bd_state", state, 1);
    set_ops(2'b11, 0, 5, 0, 7, 0, 7);
    #1;
    chk("bd_ready0", req_ready, 2'b01);
    chk("bd_madd_b0", madd_b, 5);
    tick();
    chk("bd_ready1", req_ready, 2'b10);
    chk("bd_madd_a1", madd_a, 7);
    chk("bd_madd_c1", madd_c, 7);
    tick();
    set_ops(2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    chk("bd_idle_a", madd_a, 0);
    chk("bd_idle_b", madd_b, 0);
    chk("bd_idle_c", madd_c, 0);
    chk("bd_idle_ready", req_ready, 0);
    tick();
    chk("bd_rsp0_valid", rsp_valid, 2'b01);
    chk("bd_rsp0_s", rsp_s, 0);
    tick();
    chk("bd_rsp1_valid", rsp_valid, 2'b10);
    chk("bd_rsp1_s", rsp_s, 7);
    tick();
    chk("bd_rsp_end", rsp_valid, 0);
    chk("bd_busy_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
